// File: rtl/mem_port_arbiter.sv
// Purpose: shares the single backing-memory port between I-cache line refills and data loads/stores, round-robin on ties.
// Latency: grant sampled at T -> *_req_ready and mem request at T+1; memory response at R -> requester pulse at R+1.
// Backpressure: requesters wait while busy; mem_req_* held stable until mem_req_ready; a refill is never interrupted.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ic_req_valid,
  input  logic [XLEN-1:0]               ic_req_addr,
  output logic                          ic_req_ready,
  output logic                          ic_rvalid,
  output logic [XLEN-1:0]               ic_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] ic_rword,
  output logic                          ic_rlast,
  input  logic                          d_req_valid,
  input  logic                          d_req_we,
  input  logic [XLEN-1:0]               d_req_addr,
  input  logic [XLEN-1:0]               d_req_wdata,
  input  logic [3:0]                    d_req_wstrb,
  output logic                          d_req_ready,
  output logic                          d_rvalid,
  output logic [XLEN-1:0]               d_rdata,
  output logic                          mem_req_valid,
  output logic                          mem_req_we,
  output logic [XLEN-1:0]               mem_req_addr,
  output logic [XLEN-1:0]               mem_req_wdata,
  output logic [3:0]                    mem_req_wstrb,
  input  logic                          mem_req_ready,
  input  logic                          mem_resp_valid,
  input  logic [XLEN-1:0]               mem_resp_data,
  output logic                          busy
);
  localparam int WB  = $clog2(LINE_WORDS);
  localparam int OFF = WB + 2;
  // Clears the byte-in-line offset so refills always start at word 0 of the line.
  localparam logic [XLEN-1:0] LINE_MASK = ~((XLEN'(1) << OFF) - XLEN'(1));
  // Clears the byte-in-word offset of data addresses.
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
  localparam logic [WB-1:0]   K_LAST    = WB'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, IC_REQ, IC_WAIT, D_REQ, D_WAIT} state_t;

  state_t          state;
  logic [WB-1:0]   k;
  logic            last_grant_ic;  // 1: the I-cache won the most recent grant
  logic [XLEN-1:0] ic_base;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [3:0]      d_wstrb;

  // Transaction sequencer: arbitration, request capture, word counting and registered response pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      k             <= '0;
      last_grant_ic <= 1'b1;
      ic_base       <= '0;
      d_we          <= 1'b0;
      d_addr        <= '0;
      d_wdata       <= '0;
      d_wstrb       <= '0;
      ic_req_ready  <= 1'b0;
      ic_rvalid     <= 1'b0;
      ic_rdata      <= '0;
      ic_rword      <= '0;
      ic_rlast      <= 1'b0;
      d_req_ready   <= 1'b0;
      d_rvalid      <= 1'b0;
      d_rdata       <= '0;
    end else begin
      ic_req_ready <= 1'b0;
      d_req_ready  <= 1'b0;
      ic_rvalid    <= 1'b0;
      ic_rlast     <= 1'b0;
      d_rvalid     <= 1'b0;
      unique case (state)
        IDLE: begin
          // On a tie the requester that did not win last time goes first.
          if (d_req_valid && (!ic_req_valid || last_grant_ic)) begin
            d_we          <= d_req_we;
            d_addr        <= d_req_addr & WORD_MASK;
            d_wdata       <= d_req_wdata;
            d_wstrb       <= d_req_wstrb;
            d_req_ready   <= 1'b1;
            last_grant_ic <= 1'b0;
            state         <= D_REQ;
          end else if (ic_req_valid) begin
            ic_base       <= ic_req_addr & LINE_MASK;
            k             <= '0;
            ic_req_ready  <= 1'b1;
            last_grant_ic <= 1'b1;
            state         <= IC_REQ;
          end
        end
        IC_REQ: begin
          if (mem_req_ready) state <= IC_WAIT;
        end
        IC_WAIT: begin
          if (mem_resp_valid) begin
            ic_rvalid <= 1'b1;
            ic_rdata  <= mem_resp_data;
            ic_rword  <= k;
            if (k == K_LAST) begin
              ic_rlast <= 1'b1;
              state    <= IDLE;
            end else begin
              k     <= k + WB'(1);
              state <= IC_REQ;
            end
          end
        end
        D_REQ: begin
          if (mem_req_ready) state <= D_WAIT;
        end
        D_WAIT: begin
          if (mem_resp_valid) begin
            d_rvalid <= 1'b1;
            d_rdata  <= d_we ? '0 : mem_resp_data;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory request fields decoded from the registered state and captured request; zero outside request states.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    case (state)
      IC_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = ic_base + (XLEN'(k) << 2);
      end
      D_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = d_we;
        mem_req_addr  = d_addr;
        mem_req_wdata = d_wdata;
        mem_req_wstrb = d_wstrb;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: scoreboard bench for mem_port_arbiter; stimulus pushes expectations, a monitor pops and compares.
// Latency: checks first-transaction timing (load at T+3, refill last word at T+9) against a cycle counter.
// Backpressure: memory model can hold mem_req_ready low for a programmed number of cycles.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ic_req_valid, ic_req_ready, ic_rvalid, ic_rlast;
  logic [31:0] ic_req_addr, ic_rdata;
  logic [1:0]  ic_rword;
  logic        d_req_valid, d_req_we, d_req_ready, d_rvalid;
  logic [31:0] d_req_addr, d_req_wdata, d_rdata;
  logic [3:0]  d_req_wstrb;
  logic        mem_req_valid, mem_req_we, mem_req_ready, mem_resp_valid, busy;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [3:0]  mem_req_wstrb;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_rword(ic_rword), .ic_rlast(ic_rlast),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} mreq_t;
  typedef struct {logic [31:0] data; logic [1:0] word; logic last; int cyc;} icx_t;
  typedef struct {logic [31:0] data; int cyc;} dx_t;

  mreq_t mq[$];
  icx_t  icq[$];
  dx_t   dq[$];
  logic  gq[$];  // expected grant order, 1 = I-cache, 0 = data

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          stall = 0;
  logic        chk_order = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pdata = '0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return a ^ 32'hA5A5_0F0F;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: one response per accepted request, in the cycle after the handshake.
  always @(negedge clk) begin
    mem_resp_valid = pend;
    mem_resp_data  = pend ? pdata : 32'h0;
    pend = 1'b0;
    mem_req_ready = (stall == 0);
    if (stall > 0) stall--;
    if (mem_req_valid && mem_req_ready) begin
      pend  = 1'b1;
      pdata = memf(mem_req_addr);
    end
  end

  // Monitor: compares every DUT-presented output against the head of its expectation queue.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (ic_req_ready) begin
        check("ic_grant_pending", gq.size() != 0, 1'b1);
        if (gq.size() != 0) check("grant_order_ic", 1'b1, gq.pop_front());
      end
      if (d_req_ready) begin
        check("d_grant_pending", gq.size() != 0, 1'b1);
        if (gq.size() != 0) check("grant_order_d", 1'b0, gq.pop_front());
        if (chk_order) check("d_grant_after_refill", icq.size(), 0);
      end
      if (mem_req_valid) begin
        mreq_t act_m;
        act_m = '{mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb};
        check("mem_req_pending", mq.size() != 0, 1'b1);
        if (mq.size() != 0) begin
          check("mem_req_fields", act_m, mq[0]);
          if (mem_req_ready) void'(mq.pop_front());
        end
      end
      if (ic_rvalid) begin
        check("ic_resp_pending", icq.size() != 0, 1'b1);
        if (icq.size() != 0) begin
          icx_t e;
          e = icq.pop_front();
          check("ic_rdata", ic_rdata, e.data);
          check("ic_rword", ic_rword, e.word);
          check("ic_rlast", ic_rlast, e.last);
          if (e.cyc >= 0) check("ic_rvalid_cycle", cyc, e.cyc);
        end
      end
      if (d_rvalid) begin
        check("d_resp_pending", dq.size() != 0, 1'b1);
        if (dq.size() != 0) begin
          dx_t e;
          e = dq.pop_front();
          check("d_rdata", d_rdata, e.data);
          if (e.cyc >= 0) check("d_rvalid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] rd, input int c);
    mq.push_back('{we, a, wd, ws});
    dq.push_back('{rd, c});
  endtask

  // Expected line refill from a hand-computed base; t0 < 0 skips timing checks.
  task automatic push_line(input logic [31:0] base, input int t0);
    for (int j = 0; j < 4; j++) begin
      mq.push_back('{1'b0, base + 32'(4 * j), 32'h0, 4'h0});
      icq.push_back('{memf(base + 32'(4 * j)), 2'(j), (j == 3), (t0 < 0) ? -1 : t0 + 3 + 2 * j});
    end
  endtask

  task automatic req_ic(input logic [31:0] a);
    int n = 0;
    ic_req_valid = 1'b1;
    ic_req_addr  = a;
    do begin @(negedge clk); n++; end while (!ic_req_ready && n < 100);
    check("ic_accept", ic_req_ready, 1'b1);
    ic_req_valid = 1'b0;
    ic_req_addr  = '0;
  endtask

  task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    int n = 0;
    d_req_valid = 1'b1;
    d_req_we    = we;
    d_req_addr  = a;
    d_req_wdata = wd;
    d_req_wstrb = ws;
    do begin @(negedge clk); n++; end while (!d_req_ready && n < 100);
    check("d_accept", d_req_ready, 1'b1);
    d_req_valid = 1'b0;
    d_req_we    = 1'b0;
    d_req_addr  = '0;
    d_req_wdata = '0;
    d_req_wstrb = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((mq.size() + icq.size() + dq.size() + gq.size()) != 0 && n < 300) begin
      @(negedge clk);
      #3;
      n++;
    end
    check(name, mq.size() + icq.size() + dq.size() + gq.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    check(name, {ic_req_ready, ic_rvalid, ic_rdata, ic_rword, ic_rlast, d_req_ready, d_rvalid,
                 d_rdata, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb, busy}, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit found;
    ic_req_valid = 0; ic_req_addr = '0;
    d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_req_wstrb = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_zero("reset_outputs");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Tie right after reset: data first, then the refill of line 0x300.
    gq.push_back(1'b0); gq.push_back(1'b1);
    push_d(1'b0, 32'h40, 32'h0, 4'h0, memf(32'h40), -1);
    push_line(32'h300, -1);
    fork
      req_d(1'b0, 32'h42, 32'h0, 4'h0);
      req_ic(32'h30C);
    join
    drain("tie1_drain");

    // Single minimum-latency load: 0x1003 -> 0x1000, data at T+3.
    gq.push_back(1'b0);
    push_d(1'b0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, cyc + 3);
    req_d(1'b0, 32'h1003, 32'h0, 4'h0);
    drain("load_drain");

    // Second tie after a data grant: refill of 0x20C (line 0x200) first, then a store.
    gq.push_back(1'b1); gq.push_back(1'b0);
    push_line(32'h200, cyc);
    push_d(1'b1, 32'h2004, 32'hCAFE_F00D, 4'b0110, 32'h0, -1);
    fork
      req_ic(32'h20C);
      req_d(1'b1, 32'h2006, 32'hCAFE_F00D, 4'b0110);
    join
    drain("tie2_drain");

    // Data request during a refill whose word-1 request is stalled for 3 cycles.
    chk_order = 1'b1;
    gq.push_back(1'b1); gq.push_back(1'b0);
    push_line(32'h500, -1);
    push_d(1'b0, 32'h700, 32'h0, 4'h0, memf(32'h700), -1);
    fork
      req_ic(32'h504);
      begin
        repeat (2) @(negedge clk);
        @(posedge clk);
        stall = 3;
        @(negedge clk);
        req_d(1'b0, 32'h701, 32'h0, 4'h0);
      end
    join
    drain("stall_drain");
    chk_order = 1'b0;

    // Refill at the top of the address space.
    gq.push_back(1'b1);
    push_line(32'hFFFF_FFF0, cyc);
    req_ic(32'hFFFF_FFF4);
    drain("wrap_drain");

    // Reset while waiting for word 2 of a refill: everything dropped, then a fresh store.
    gq.push_back(1'b1);
    push_line(32'h600, -1);
    req_ic(32'h608);
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (ic_rvalid && ic_rword == 2'd1) found = 1;
    end
    check("saw_word1", found, 1'b1);
    @(negedge clk);
    mq.delete(); icq.delete(); dq.delete(); gq.delete();
    reset = 1'b1;
    @(negedge clk);
    #1 check_zero("reset_mid_outputs");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    gq.push_back(1'b0);
    push_d(1'b1, 32'h80, 32'h1122_3344, 4'hF, 32'h0, cyc + 3);
    req_d(1'b1, 32'h80, 32'h1122_3344, 4'hF);
    drain("post_reset_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
